// File: rtl/crc_pkg.sv
// Shared constants and state encoding for the serial CRC blocks
// (checker, serial encoder and error logger).
package crc_pkg;

    localparam int                 CRC_N   = 16;
    localparam int                 CRC_R   = 7;
    localparam logic [CRC_R-1:0]   CRC_DIV = 7'b1111011;
    localparam int                 CRC_CW  = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } crc_state_t;

endpackage

// File: rtl/crc_div_step.sv
// One bit of GF(2) polynomial long division: conditional reduce, then shift
// the next dividend bit into the remainder.
module crc_div_step
    import crc_pkg::*;
#(
    parameter int             R   = CRC_R,
    parameter logic [R-1:0]   DIV = CRC_DIV
) (
    input  logic [R-1:0] i_rem,
    input  logic         i_bit,
    output logic [R-1:0] o_reduced,
    output logic [R-1:0] o_next
);

    assign o_reduced = i_rem[R-1] ? (i_rem ^ DIV) : i_rem;
    assign o_next    = {o_reduced[R-2:0], i_bit};

endmodule

// File: rtl/crc_check_sequencer.sv
// Bit-serial CRC checker: one division step per cycle over N cycles, result
// held on a valid/ready output, plus saturating good/bad frame counters.
module crc_check_sequencer
    import crc_pkg::*;
#(
    parameter int             N   = CRC_N,
    parameter int             R   = CRC_R,
    parameter logic [R-1:0]   DIV = CRC_DIV,
    parameter int             CW  = CRC_CW
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [N+R-2:0]   in_stream,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [N-1:0]     out_data,
    output logic [R-2:0]     out_syndrome,
    output logic             out_error,
    output logic [CW-1:0]    cnt_ok,
    output logic [CW-1:0]    cnt_err,
    input  logic             cnt_clr
);

    localparam int             BW        = $clog2(N);
    localparam logic [BW-1:0]  BCNT_LAST = BW'(N - 1);

    crc_state_t      r_state;
    crc_state_t      w_state_nxt;
    logic [N-1:0]    r_data;
    logic [R-1:0]    r_rem;
    logic [N-2:0]    r_sreg;
    logic [BW-1:0]   r_bcnt;
    logic [CW-1:0]   r_cnt_ok;
    logic [CW-1:0]   r_cnt_err;

    logic [R-1:0]    w_reduced;
    logic [R-1:0]    w_rem_shift;
    logic            w_accept;
    logic            w_out_hs;

    crc_div_step #(
        .R   (R),
        .DIV (DIV)
    ) u_div_step (
        .i_rem     (r_rem),
        .i_bit     (r_sreg[N-2]),
        .o_reduced (w_reduced),
        .o_next    (w_rem_shift)
    );

    // NOTE: state registers use non-blocking (<=) so every flop samples
    // pre-edge values; blocking here would create order-dependent races.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // NOTE: every signal driven here gets a default first so no path leaves
    // it unassigned, which would otherwise infer a latch.
    always_comb begin
        w_state_nxt = r_state;
        in_ready    = 1'b0;
        out_valid   = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    w_state_nxt = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (r_bcnt == '0) begin
                    w_state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    assign w_accept = in_valid && in_ready;
    assign w_out_hs = out_valid && out_ready;

    // The top R dividend bits seed the remainder; the remaining N-1 bits
    // stream in MSB first from r_sreg, one per SHIFT cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_data <= '0;
            r_rem  <= '0;
            r_sreg <= '0;
            r_bcnt <= '0;
        end else begin
            if (w_accept) begin
                r_data <= in_stream[N+R-2:R-1];
                r_rem  <= in_stream[N+R-2:N-1];
                r_sreg <= in_stream[N-2:0];
                r_bcnt <= BCNT_LAST;
            end else if (r_state == ST_SHIFT) begin
                if (r_bcnt != '0) begin
                    r_rem  <= w_rem_shift;
                    r_sreg <= {r_sreg[N-3:0], 1'b0};
                    r_bcnt <= r_bcnt - BW'(1);
                end else begin
                    r_rem  <= w_reduced;
                end
            end
        end
    end

    // Clear wins over a same-cycle increment; both counters stick at all-ones.
    always_ff @(posedge clk) begin
        if (rst || cnt_clr) begin
            r_cnt_ok  <= '0;
            r_cnt_err <= '0;
        end else if (w_out_hs) begin
            if (out_error) begin
                if (r_cnt_err != '1) begin
                    r_cnt_err <= r_cnt_err + CW'(1);
                end
            end else begin
                if (r_cnt_ok != '1) begin
                    r_cnt_ok <= r_cnt_ok + CW'(1);
                end
            end
        end
    end

    assign out_data     = r_data;
    assign out_syndrome = r_rem[R-2:0];
    assign out_error    = |r_rem[R-2:0];
    assign cnt_ok       = r_cnt_ok;
    assign cnt_err      = r_cnt_err;

endmodule

// File: tb/tb_crc_check_sequencer.sv
// Scoreboard bench for crc_check_sequencer: stimulus pushes expected results
// computed by plain polynomial long division; a negedge monitor checks them.
module tb_crc_check_sequencer;

    localparam int            N    = 16;
    localparam int            R    = 7;
    localparam int            CW   = 4;
    localparam int            W    = N + R - 1;
    localparam logic [R-1:0]  POLY = 7'b1111011;

    logic           clk = 1'b0;
    logic           rst;
    logic           in_valid;
    logic           in_ready;
    logic [W-1:0]   in_stream;
    logic           out_valid;
    logic           out_ready;
    logic [N-1:0]   out_data;
    logic [R-2:0]   out_syndrome;
    logic           out_error;
    logic [CW-1:0]  cnt_ok;
    logic [CW-1:0]  cnt_err;
    logic           cnt_clr;

    crc_check_sequencer #(.CW(CW)) dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_stream    (in_stream),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_data     (out_data),
        .out_syndrome (out_syndrome),
        .out_error    (out_error),
        .cnt_ok       (cnt_ok),
        .cnt_err      (cnt_err),
        .cnt_clr      (cnt_clr)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [N-1:0]  data;
        logic [R-2:0]  syn;
        logic          err;
        int            acc;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    bit   rdy_rand = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Remainder of the whole codeword modulo the generator, by long division.
    function automatic logic [R-2:0] crc_rem(input logic [W-1:0] cw);
        logic [W-1:0] v;
        v = cw;
        for (int i = W - 1; i >= R - 1; i--) begin
            if (v[i]) v = v ^ (W'(POLY) << (i - (R - 1)));
        end
        return v[R-2:0];
    endfunction

    function automatic logic [W-1:0] make_good(input logic [N-1:0] d);
        logic [W-1:0] cw;
        cw = {d, {(R-1){1'b0}}};
        return cw | W'(crc_rem(cw));
    endfunction

    // ---------------- monitor / scoreboard ----------------
    bit            m_started = 1'b0;
    bit            m_after_rst = 1'b0;
    bit            m_after_hs = 1'b0;
    bit            m_prev_valid = 1'b0;
    bit            m_prev_ready = 1'b0;
    logic [N-1:0]  m_prev_data;
    logic [R-2:0]  m_prev_syn;
    logic          m_prev_err;
    int            m_ok = 0;
    int            m_err = 0;

    always @(negedge clk) begin
        bit   hs;
        exp_t e;
        if (m_started) begin
            check("cnt_ok", 64'(cnt_ok), 64'(m_ok));
            check("cnt_err", 64'(cnt_err), 64'(m_err));
        end
        if (m_after_rst) begin
            check("rst_in_ready", 64'(in_ready), 64'd1);
            check("rst_out_valid", 64'(out_valid), 64'd0);
            check("rst_out_data", 64'(out_data), 64'd0);
            check("rst_out_syndrome", 64'(out_syndrome), 64'd0);
            check("rst_out_error", 64'(out_error), 64'd0);
        end
        if (m_after_hs) begin
            check("post_hs_in_ready", 64'(in_ready), 64'd1);
            check("post_hs_out_valid", 64'(out_valid), 64'd0);
        end
        if (out_valid && !rst) begin
            check("busy_in_ready", 64'(in_ready), 64'd0);
            if (!m_prev_valid) begin
                if (sb.size() == 0) check("unexpected_out_valid", 64'(sb.size()), 64'd1);
                else check("latency", 64'(cyc - sb[0].acc), 64'd16);
            end else if (!m_prev_ready) begin
                check("stall_data", 64'(out_data), 64'(m_prev_data));
                check("stall_syndrome", 64'(out_syndrome), 64'(m_prev_syn));
                check("stall_error", 64'(out_error), 64'(m_prev_err));
            end
        end
        hs = out_valid && out_ready && !rst;
        e.err = 1'b0;
        if (hs) begin
            if (sb.size() == 0) begin
                check("sb_underflow", 64'(sb.size()), 64'd1);
            end else begin
                e = sb.pop_front();
                check("out_data", 64'(out_data), 64'(e.data));
                check("out_syndrome", 64'(out_syndrome), 64'(e.syn));
                check("out_error", 64'(out_error), 64'(e.err));
            end
        end
        if (rst || cnt_clr) begin
            m_ok  = 0;
            m_err = 0;
        end else if (hs) begin
            if (e.err) m_err = (m_err == (1 << CW) - 1) ? m_err : m_err + 1;
            else       m_ok  = (m_ok  == (1 << CW) - 1) ? m_ok  : m_ok + 1;
        end
        m_after_rst  = rst;
        m_after_hs   = hs;
        m_started    = m_started | rst;
        m_prev_valid = out_valid && !rst;
        m_prev_ready = out_ready;
        m_prev_data  = out_data;
        m_prev_syn   = out_syndrome;
        m_prev_err   = out_error;
    end

    // ---------------- stimulus ----------------
    initial begin
        forever begin
            @(posedge clk);
            #2;
            if (rdy_rand) out_ready = ($urandom_range(0, 1) == 1);
        end
    end

    task automatic send(input logic [W-1:0] cw);
        int n;
        logic [R-2:0] s;
        n = 0;
        @(posedge clk); #1;
        while (!in_ready && n < 300) begin
            @(posedge clk); #1;
            n++;
        end
        if (!in_ready) begin
            check("accept_timeout", 64'(in_ready), 64'd1);
            return;
        end
        s = crc_rem(cw);
        in_valid  = 1'b1;
        in_stream = cw;
        sb.push_back('{data: cw[W-1:R-1], syn: s, err: (s != '0), acc: cyc + 1});
        @(posedge clk); #1;
        in_valid  = 1'b0;
    endtask

    task automatic wait_valid();
        int n;
        n = 0;
        while (!out_valid && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        if (!out_valid) check("valid_timeout", 64'(out_valid), 64'd1);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((sb.size() != 0 || out_valid) && n < 3000) begin
            @(posedge clk); #1;
            n++;
        end
        if (sb.size() != 0) check("drain_timeout", 64'(sb.size()), 64'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_stream = '0;
        out_ready = 1'b1;
        cnt_clr   = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Directed codewords: all-zero, bare data bit, matching check, one flipped bit.
        send(22'h000000); drain();
        send(22'h000040); drain();
        send(22'h00007B); drain();
        send(22'h00007B ^ 22'h000400); drain();

        // Consumer stall: outputs must hold and no new accept.
        out_ready = 1'b0;
        send(make_good(16'hA5C3));
        wait_valid();
        repeat (5) @(posedge clk);
        #1 out_ready = 1'b1;
        drain();

        // Reset in the middle of the shift phase discards the frame.
        send(22'h3FFFFF);
        repeat (6) @(posedge clk);
        #1 rst = 1'b1;
        sb.delete();
        @(posedge clk);
        #1 rst = 1'b0;
        send(make_good(16'h1234)); drain();

        // Random mix of clean and corrupted codewords with random back-pressure.
        rdy_rand = 1'b1;
        for (int i = 0; i < 150; i++) begin
            logic [W-1:0] cw;
            if ($urandom_range(0, 1) == 1) cw = make_good(N'($urandom));
            else                           cw = W'($urandom);
            send(cw);
        end
        drain();
        rdy_rand = 1'b0;

        // Saturation of the error counter and clear racing a handshake.
        @(posedge clk); #1;
        out_ready = 1'b1;
        cnt_clr   = 1'b1;
        @(posedge clk); #1;
        cnt_clr   = 1'b0;
        for (int i = 0; i < 20; i++) begin
            send(make_good(N'($urandom)) ^ W'(1));
            drain();
        end
        out_ready = 1'b0;
        send(make_good(16'h0F0F));
        wait_valid();
        @(posedge clk); #1;
        out_ready = 1'b1;
        cnt_clr   = 1'b1;
        @(posedge clk); #1;
        cnt_clr   = 1'b0;
        drain();
        repeat (3) @(posedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
